// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Shared constants and helpers for the serial configuration shift register.
//   DATA_LEN      : default chain length used by the serial interface (8)
//   shift_word_t  : one control word of DATA_LEN bits
//   cnt_width()   : number of bits needed to count 0..len inclusive
// -----------------------------------------------------------------------------
package shift_register_pkg;

  localparam int unsigned DATA_LEN = 32'd8;

  typedef logic [DATA_LEN-1:0] shift_word_t;

  // Width of a counter that must hold every value from 0 up to len.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 32'd1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Saturating count of enabled shifts since the last update, used to flag that
// a complete word is sitting in the shift stage.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high clear
//   shift_en in   a shift happens on this edge
//   clear    in   update pulse; restarts the count
//   full     out  registered, 1 when the count equals DATA_LEN
// -----------------------------------------------------------------------------
module shift_bit_counter
  import shift_register_pkg::*;
#(
  parameter int unsigned LEN = shift_register_pkg::DATA_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic clear,
  output logic full
);

  localparam int unsigned CW = cnt_width(LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  // Next count: an update coinciding with a shift starts the new word at 1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear && shift_en) begin
      cnt_nxt_s = CNT_ONE;
    end else if (clear) begin
      cnt_nxt_s = '0;
    end else if (shift_en && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register and registered full flag (flag tracks the new count).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      full  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      full  <= (cnt_nxt_s == CNT_MAX);
    end
  end

endmodule

// File: rtl/serial_shift_register.sv
// -----------------------------------------------------------------------------
// serial_shift_register
// Serial-in / parallel-out configuration register with a shadow stage. Bits
// shift in MSB-first while enable is high; an update pulse copies the shift
// stage into bit_out, which holds while the next word shifts in. data_out is
// the shift stage MSB so instances can be daisy-chained.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high; clears all state
//   data_in   in   serial bit, sampled when enable = 1
//   enable    in   shift enable
//   update    in   copy shift stage (pre-edge value) into bit_out
//   data_out  out  shift stage MSB (a register bit, no extra flop)
//   bit_out   out  DATA_LEN-bit shadow register
//   full      out  only when SHIFT_REG_BITCNT_EN is defined: DATA_LEN shifts
//                  seen since the last update
// Build option: SHIFT_REG_BITCNT_EN adds the shift counter and the full port.
// -----------------------------------------------------------------------------
module serial_shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned DATA_LEN = shift_register_pkg::DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_in,
  input  logic                enable,
  input  logic                update,
  output logic                data_out,
  output logic [DATA_LEN-1:0] bit_out
`ifdef SHIFT_REG_BITCNT_EN
  ,
  output logic                full
`endif
);

  logic [DATA_LEN-1:0] sr_r;

  // Shift stage: new bit enters at bit 0, oldest bit leaves from the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_r <= '0;
    end else if (enable) begin
      sr_r <= {sr_r[DATA_LEN-2:0], data_in};
    end else begin
      sr_r <= sr_r;
    end
  end

  // Shadow stage: captures the pre-shift word, so a same-cycle shift loses nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_out <= '0;
    end else if (update) begin
      bit_out <= sr_r;
    end else begin
      bit_out <= bit_out;
    end
  end

  assign data_out = sr_r[DATA_LEN-1];

`ifdef SHIFT_REG_BITCNT_EN
  shift_bit_counter #(
    .LEN (DATA_LEN)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .shift_en (enable),
    .clear    (update),
    .full     (full)
  );
`endif

endmodule

// File: tb/tb_serial_shift_register.sv
// -----------------------------------------------------------------------------
// tb_serial_shift_register
// Scoreboard bench: each update (or reset) pushes the word bit_out must show
// after the edge; the word is popped and compared once the edge has passed.
// data_out (and full, when built with SHIFT_REG_BITCNT_EN) is checked every
// cycle against a small reference model.
// -----------------------------------------------------------------------------
module tb_serial_shift_register;

  localparam int unsigned DL = 8;

  logic          clk;
  logic          reset;
  logic          data_in;
  logic          enable;
  logic          update;
  logic          data_out;
  logic [DL-1:0] bit_out;
`ifdef SHIFT_REG_BITCNT_EN
  logic          full;
`endif

  serial_shift_register #(.DATA_LEN(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .enable   (enable),
    .update   (update),
    .data_out (data_out),
    .bit_out  (bit_out)
`ifdef SHIFT_REG_BITCNT_EN
    ,
    .full     (full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DL-1:0] mdl_sr;
  logic [DL-1:0] mdl_bo;
  int            mdl_cnt;
  logic [DL-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec = n_vec + 1;
    if (obs !== expv) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: drive at negedge, advance the model at the edge, check after it.
  task automatic step(input logic rst, input logic en, input logic din, input logic upd);
    logic [DL-1:0] w;
    @(negedge clk);
    reset = rst; enable = en; data_in = din; update = upd;
    if (rst) begin
      mdl_sr = '0; mdl_bo = '0; mdl_cnt = 0;
      exp_q.push_back('0);
    end else begin
      if (upd) begin
        mdl_bo = mdl_sr;
        exp_q.push_back(mdl_sr);
      end
      if (en && upd)       mdl_cnt = 1;
      else if (upd)        mdl_cnt = 0;
      else if (en && mdl_cnt < DL) mdl_cnt = mdl_cnt + 1;
      if (en) mdl_sr = {mdl_sr[DL-2:0], din};
    end
    @(posedge clk);
    #1;
    chk("data_out", 64'(data_out), 64'(mdl_sr[DL-1]));
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("bit_out", 64'(bit_out), 64'(w));
    end
`ifdef SHIFT_REG_BITCNT_EN
    chk("full", 64'(full), 64'(mdl_cnt == DL));
`endif
  endtask

  task automatic shift_word(input logic [DL-1:0] w);
    for (int i = DL - 1; i >= 0; i--) step(1'b0, 1'b1, w[i], 1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; data_in = 1'b1; update = 1'b0;
    mdl_sr = '0; mdl_bo = '0; mdl_cnt = 0;

    // Reset with enable and data_in high: everything stays zero.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_bo", 64'(bit_out), 64'h0);

    // Fill with ones, then update while shifting a zero.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("fill_ff", 64'(bit_out), 64'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fill_sr_fe", 64'(bit_out), 64'hFE);

    // MSB-first pattern A5.
    shift_word(8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pattern_a5", 64'(bit_out), 64'hA5);

    // Hold: enable low, data_in toggling.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hold_a5", 64'(bit_out), 64'hA5);

    // Mid-word reset, then a fresh 3C word.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midreset_bo", 64'(bit_out), 64'h0);
    shift_word(8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("word_3c", 64'(bit_out), 64'h3C);

    // Counter boundaries: 7, 8, 9 shifts, then update alone.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'(i % 3 == 0), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow and held update: bit_out tracks sr every cycle.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'(i % 2), 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 1'(i < 2), 1'b1);

    // Random mix of all controls.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
